// File: rtl/izh_pkg.sv
// rtl/izh_pkg.sv - shared types, constants and sign-magnitude helpers for the Izhikevich core
//
// Purpose : word geometry, state-update FSM encoding, Q16.16 sign-magnitude
//           constants and helper functions shared by the state-update stage.
// Contents: N, Q, izh_state_e, SM_ONE, SM_NEG_ONE, SM_MAX_MAG, sm_ge(), sm_norm()
package izh_pkg;

    localparam int N = 32;
    localparam int Q = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } izh_state_e;

    localparam logic [N-1:0] SM_ONE     = 32'h00010000;
    localparam logic [N-1:0] SM_NEG_ONE = 32'h80010000;
    localparam logic [N-1:0] SM_MAX_MAG = 32'h7FFFFFFF;

    // Signed a >= b on sign-magnitude words; -0 is treated as +0.
    function automatic logic sm_ge(input logic [N-1:0] a, input logic [N-1:0] b);
        logic a_neg;
        logic b_neg;
        a_neg = a[N-1] && (a[N-2:0] != '0);
        b_neg = b[N-1] && (b[N-2:0] != '0);
        if (a_neg != b_neg) begin
            sm_ge = b_neg;
        end else if (a_neg) begin
            sm_ge = (a[N-2:0] <= b[N-2:0]);
        end else begin
            sm_ge = (a[N-2:0] >= b[N-2:0]);
        end
    endfunction

    // Collapse negative zero to the canonical all-zeros word.
    function automatic logic [N-1:0] sm_norm(input logic [N-1:0] a);
        sm_norm = (a[N-2:0] == '0) ? '0 : a;
    endfunction

endpackage

// File: rtl/izh_state_update_sm_add.sv
// rtl/izh_state_update_sm_add.sv - combinational saturating sign-magnitude adder
//
// Purpose : sum_o = sat(a_i + b_i) in sign-magnitude form. Magnitude overflow
//           clamps to all-ones magnitude with the operands' common sign; a
//           zero result is always emitted as +0.
// Ports   : a_i, b_i  [N-1:0] operands
//           sum_o     [N-1:0] normalised saturated sum
module sm_add #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);

    logic         sign_a;
    logic         sign_b;
    logic [N-2:0] mag_a;
    logic [N-2:0] mag_b;
    logic [N-1:0] mag_wide;
    logic [N-2:0] mag_res;
    logic         sign_res;

    assign sign_a = a_i[N-1];
    assign sign_b = b_i[N-1];
    assign mag_a  = a_i[N-2:0];
    assign mag_b  = b_i[N-2:0];

    always_comb begin
        mag_wide = '0;
        mag_res  = '0;
        sign_res = 1'b0;
        if (sign_a == sign_b) begin
            // One extra bit catches the magnitude carry-out for saturation.
            mag_wide = {1'b0, mag_a} + {1'b0, mag_b};
            mag_res  = mag_wide[N-1] ? '1 : mag_wide[N-2:0];
            sign_res = sign_a;
        end else if (mag_a >= mag_b) begin
            mag_res  = mag_a - mag_b;
            sign_res = sign_a;
        end else begin
            mag_res  = mag_b - mag_a;
            sign_res = sign_b;
        end
    end

    assign sum_o = (mag_res == '0) ? '0 : {sign_res, mag_res};

endmodule

// File: rtl/izh_state_update.sv
// rtl/izh_state_update.sv - registered v/w integration and spike rule of the Izhikevich core
//
// Purpose : accepts one step of dv/dw/c/d, integrates v and w with saturating
//           sign-magnitude adds, applies the spike/reset rule and presents the
//           result until downstream takes it.
// Ports   : clk, rst_n                    clock, async active-low reset
//           in_valid/in_ready             step input handshake
//           dv, dw, c, d     [N-1:0]      step operands
//           v, w             [N-1:0]      registered neuron state
//           spike                         spike flag, qualified by out_valid
//           out_valid/out_ready           result handshake
//           step_count       [15:0]       completed steps, wrapping
module izh_state_update
    import izh_pkg::*;
#(
    parameter int           N      = 32,
    parameter int           Q      = 16,
    parameter logic [N-1:0] V_TH   = 32'h001E0000,
    parameter logic [N-1:0] V_INIT = 32'h80410000,
    parameter logic [N-1:0] W_INIT = 32'h800D0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dv,
    input  logic [N-1:0] dw,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    output logic [N-1:0] v,
    output logic [N-1:0] w,
    output logic         spike,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  step_count
);

    if (Q >= N - 1) begin : g_bad_q
        $error("Q leaves no integer bits in the word");
    end

    izh_state_e   state_q, state_d;
    logic [N-1:0] v_q, v_d;
    logic [N-1:0] w_q, w_d;
    logic [N-1:0] dv_q, dv_d;
    logic [N-1:0] dw_q, dw_d;
    logic [N-1:0] c_q, c_d;
    logic [N-1:0] d_q, d_d;
    logic         spike_q, spike_d;
    logic [15:0]  cnt_q, cnt_d;

    logic [N-1:0] v_sum;
    logic [N-1:0] w_addend;
    logic [N-1:0] w_sum;

    // The w adder is shared: dw during UPDATE, the post-spike d during CHECK.
    assign w_addend = (state_q == CHECK) ? d_q : dw_q;

    sm_add #(.N(N)) u_v_add (
        .a_i   (v_q),
        .b_i   (dv_q),
        .sum_o (v_sum)
    );

    sm_add #(.N(N)) u_w_add (
        .a_i   (w_q),
        .b_i   (w_addend),
        .sum_o (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= V_INIT;
            w_q     <= W_INIT;
            dv_q    <= '0;
            dw_q    <= '0;
            c_q     <= '0;
            d_q     <= '0;
            spike_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            w_q     <= w_d;
            dv_q    <= dv_d;
            dw_q    <= dw_d;
            c_q     <= c_d;
            d_q     <= d_d;
            spike_q <= spike_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        w_d     = w_q;
        dv_d    = dv_q;
        dw_d    = dw_q;
        c_d     = c_q;
        d_d     = d_q;
        spike_d = spike_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dv_d    = dv;
                    dw_d    = dw;
                    c_d     = c;
                    d_d     = d;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                v_d     = v_sum;
                w_d     = w_sum;
                state_d = CHECK;
            end
            CHECK: begin
                if (sm_ge(v_q, V_TH)) begin
                    v_d     = sm_norm(c_q);
                    w_d     = w_sum;
                    spike_d = 1'b1;
                end else begin
                    spike_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    spike_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign v          = v_q;
    assign w          = w_q;
    assign spike      = spike_q;
    assign step_count = cnt_q;

endmodule
